// File: rtl/csa_accumulator.sv
// Multi-operand accumulator: operands fold into a carry-save sum/carry pair,
// and a chunked carry-propagate pass resolves the pair when finish is requested.
//
// state   | meaning
// IDLE    | no operand taken since the last clear
// ACCUM   | at least one operand folded into S/C
// RESOLVE | chunked carry-propagate of S+C in progress
// DONE    | result held until out_ready
module csa_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int CPA_CHUNK = 4,
  parameter int COUNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic                 finish,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 overflow,
  output logic [COUNT_W-1:0]   count,
  output logic                 busy
);

  localparam int NCHUNK = ACC_WIDTH / CPA_CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]           state;
  logic [ACC_WIDTH-1:0] s_reg;
  logic [ACC_WIDTH-1:0] c_reg;
  logic                 dropped;
  logic [IDXW-1:0]      chunk_idx;
  logic                 chunk_carry;

  logic [ACC_WIDTH-1:0] x_ext;
  logic [ACC_WIDTH-1:0] maj;
  logic [ACC_WIDTH-1:0] s_nxt;
  logic [ACC_WIDTH-1:0] c_nxt;
  logic                 take;
  logic                 last_chunk;
  logic [CPA_CHUNK-1:0] s_chunk;
  logic [CPA_CHUNK-1:0] c_chunk;
  logic [CPA_CHUNK:0]   chunk_res;
  logic [ACC_WIDTH-1:0] out_sum_nxt;

  assign in_ready   = (state == IDLE) || (state == ACCUM);
  assign busy       = (state == RESOLVE) || (state == DONE);
  assign take       = in_valid && in_ready;
  assign last_chunk = (chunk_idx == IDXW'(NCHUNK - 1));

  // 3:2 compression; the majority MSB shifted out is remembered as overflow
  assign x_ext = ACC_WIDTH'(in_data);
  assign maj   = (s_reg & c_reg) | (s_reg & x_ext) | (c_reg & x_ext);
  assign s_nxt = s_reg ^ c_reg ^ x_ext;
  assign c_nxt = maj << 1;

  always_comb begin
    s_chunk     = '0;
    c_chunk     = '0;
    out_sum_nxt = out_sum;
    for (int k = 0; k < NCHUNK; k++) begin
      if (chunk_idx == IDXW'(k)) begin
        s_chunk = s_reg[k*CPA_CHUNK +: CPA_CHUNK];
        c_chunk = c_reg[k*CPA_CHUNK +: CPA_CHUNK];
      end
    end
    chunk_res = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CPA_CHUNK{1'b0}}, chunk_carry};
    for (int k = 0; k < NCHUNK; k++) begin
      if (chunk_idx == IDXW'(k)) begin
        out_sum_nxt[k*CPA_CHUNK +: CPA_CHUNK] = chunk_res[CPA_CHUNK-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_reg       <= '0;
      c_reg       <= '0;
      dropped     <= 1'b0;
      chunk_idx   <= '0;
      chunk_carry <= 1'b0;
      out_sum     <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (take) begin
            s_reg <= s_nxt;
            c_reg <= c_nxt;
            if (maj[ACC_WIDTH-1]) begin
              dropped <= 1'b1;
            end
            if (count != {COUNT_W{1'b1}}) begin
              count <= count + COUNT_W'(1);
            end
          end
          // a same-cycle operand is already in s_nxt/c_nxt when RESOLVE begins
          if (finish) begin
            state       <= RESOLVE;
            chunk_idx   <= '0;
            chunk_carry <= 1'b0;
          end else if (take) begin
            state <= ACCUM;
          end
        end
        RESOLVE: begin
          out_sum     <= out_sum_nxt;
          chunk_carry <= chunk_res[CPA_CHUNK];
          if (last_chunk) begin
            overflow  <= dropped | chunk_res[CPA_CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
            chunk_idx <= '0;
          end else begin
            chunk_idx <= chunk_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s_reg     <= '0;
            c_reg     <= '0;
            count     <= '0;
            dropped   <= 1'b0;
            overflow  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator (WIDTH=4, ACC_WIDTH=8, CPA_CHUNK=4);
// inputs change 1 time unit after each rising edge and outputs are sampled there too.
module tb_csa_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       finish;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       overflow;
  logic [7:0] count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  csa_accumulator #(
    .WIDTH(4), .ACC_WIDTH(8), .CPA_CHUNK(4), .COUNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .finish(finish), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .overflow(overflow),
    .count(count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; finish = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_out_sum", out_sum, 8'h00);
    check("rst_overflow", overflow, 0);

    // 11 + 13 + 6 = 30
    feed(4'b1011);
    feed(4'b1101);
    feed(4'b0110);
    check("t1_count_pre", count, 3);
    do_finish();
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 0);
    check("t1_valid_c1", out_valid, 0);
    step();
    check("t1_valid_c2", out_valid, 0);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 8'h1E);
    check("t1_count", count, 3);
    check("t1_ovf", overflow, 0);
    accept();
    check("t1_idle_valid", out_valid, 0);
    check("t1_idle_ready", in_ready, 1);
    check("t1_idle_count", count, 0);
    check("t1_idle_busy", busy, 0);

    // operand presented together with finish is included: 15*3 = 45
    feed(4'b1111);
    feed(4'b1111);
    in_valid = 1'b1; in_data = 4'b1111; finish = 1'b1;
    step();
    in_valid = 1'b0; in_data = 4'h0; finish = 1'b0;
    step();
    step();
    check("t2_valid", out_valid, 1);
    check("t2_sum", out_sum, 8'h2D);
    check("t2_count", count, 3);
    check("t2_ovf", overflow, 0);
    accept();

    // 15*20 = 300 -> 0x2C with overflow
    for (int i = 0; i < 20; i++) feed(4'b1111);
    do_finish();
    step();
    step();
    check("t3_valid", out_valid, 1);
    check("t3_sum", out_sum, 8'h2C);
    check("t3_ovf", overflow, 1);
    check("t3_count", count, 20);

    // stall in DONE with distracting inputs
    in_valid = 1'b1; in_data = 4'b0101; finish = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_sum", out_sum, 8'h2C);
      check("t4_hold_ready", in_ready, 0);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_count", count, 20);
      check("t4_hold_ovf", overflow, 1);
    end
    in_valid = 1'b0; in_data = 4'h0; finish = 1'b0;
    accept();
    check("t4_clr_count", count, 0);
    check("t4_clr_valid", out_valid, 0);
    check("t4_clr_ready", in_ready, 1);
    check("t4_clr_ovf", overflow, 0);
    feed(4'b0111);
    do_finish();
    step();
    step();
    check("t4_new_valid", out_valid, 1);
    check("t4_new_sum", out_sum, 8'h07);
    check("t4_new_count", count, 1);
    check("t4_new_ovf", overflow, 0);
    accept();

    // reset after chunk 0 of RESOLVE
    feed(4'b1010);
    do_finish();
    step();
    check("t5_mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_ready", in_ready, 1);
    check("t5_rst_sum", out_sum, 8'h00);
    feed(4'b0001);
    feed(4'b0010);
    do_finish();
    step();
    step();
    check("t5_valid", out_valid, 1);
    check("t5_sum", out_sum, 8'h03);
    check("t5_count", count, 2);
    accept();

    // finish with nothing accumulated
    do_finish();
    step();
    check("t6_valid_early", out_valid, 0);
    step();
    check("t6_valid", out_valid, 1);
    check("t6_sum", out_sum, 8'h00);
    check("t6_count", count, 0);
    check("t6_ovf", overflow, 0);
    accept();
    check("t6_idle", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Sequential, parametrised multi-operand accumulator built on carry-save (3:2) compression.
- Accepts one WIDTH-bit unsigned operand per cycle and folds it into a redundant sum/carry register pair with no carry propagation.
- On request, resolves the redundant pair with a chunked carry-propagate adder over several cycles, then presents the result on a valid/ready output handshake.
- Serves as the building block for multi-operand sums and MAC datapaths.

Parameters:
- WIDTH, 4, operand width in bits.
- ACC_WIDTH, 8, accumulator/result width in bits; must be ≥ WIDTH and a multiple of CPA_CHUNK.
- CPA_CHUNK, 4, bits resolved per cycle by the final adder; NCHUNK = ACC_WIDTH/CPA_CHUNK.
- COUNT_W, 8, width of the operand counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_data  in  WIDTH  unsigned operand, zero-extended to ACC_WIDTH.
- in_ready  out  1  block can accept an operand this cycle.
- finish  in  1  request resolution of the current total.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_WIDTH  resolved total, modulo 2^ACC_WIDTH.
- overflow  out  1  true unsigned total ≥ 2^ACC_WIDTH; valid with out_valid.
- count  out  COUNT_W  number of operands accumulated, saturating at all-ones.
- busy  out  1  high in RESOLVE or DONE.

Behaviour:
- Reset: rst sampled high sets state to IDLE and clears S, C, out_sum, count, overflow, out_valid and the internal dropped-carry flag. in_ready=1 in the cycle after reset. rst overrides every other input in any state, including mid-RESOLVE and DONE.
- States:
  - IDLE: no operand taken since the last clear.
  - ACCUM: at least one operand taken.
  - RESOLVE: carry-propagate in progress.
  - DONE: result held.
- in_ready = 1 in IDLE and ACCUM, 0 in RESOLVE and DONE.
- Accumulate: on an edge with in_valid && in_ready, with X = zero-extended in_data:
  - S' = S ^ C ^ X.
  - C' = majority(S, C, X) shifted left by 1, truncated to ACC_WIDTH.
  - If the majority MSB is 1 (the bit discarded by the shift), set the sticky dropped flag.
  - count increments, saturating at 2^COUNT_W−1.
  - IDLE → ACCUM.
- Finish: finish sampled high in IDLE or ACCUM moves the state to RESOLVE.
  - If in_valid is also high that cycle, that operand is accumulated first and is included in the result.
  - finish in RESOLVE or DONE is ignored.
  - finish in IDLE resolves to out_sum=0.
- RESOLVE: occupies exactly NCHUNK cycles. In cycle k (k=0..NCHUNK−1), bits [k·CPA_CHUNK +: CPA_CHUNK] of S+C plus the registered chunk carry are written into out_sum and the chunk carry register. Carry-in for chunk 0 is 0.
- End of RESOLVE: on the edge ending chunk NCHUNK−1:
  - overflow = dropped flag OR final chunk carry-out.
  - state → DONE, out_valid = 1.
  - Net effect: out_valid rises NCHUNK cycles after the edge that sampled finish.
- DONE:
  - out_sum, overflow and count are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid → 0; S, C, count, dropped flag and overflow clear; state → IDLE. out_sum keeps its last value.
- No back-to-back accumulation during RESOLVE or DONE. Upstream must hold operands; none are dropped.
- Arithmetic: unsigned only. out_sum = (Σ operands) mod 2^ACC_WIDTH. overflow is exact for unsigned totals.

Test Plan:
- WIDTH=4, ACC_WIDTH=8, CPA_CHUNK=4. After reset, feed 1011, 1101, 0110 on consecutive cycles, then pulse finish → out_valid 2 cycles later, out_sum=0x1E, count=3, overflow=0.
- Assert in_valid=1 with in_data=1111 in the same cycle as finish, after prior 1111, 1111 → operand included; out_sum=0x2D, count=3.
- Feed 1111 twenty times, then finish → out_sum=0x2C, overflow=1.
- With out_valid high, hold out_ready=0 for 5 cycles while driving in_valid and finish → out_sum stable, in_ready=0, no state change. Then out_ready=1 → IDLE with count=0; next result reflects only new operands.
- Assert rst mid-RESOLVE (after chunk 0) → the next cycle shows out_valid=0, busy=0, count=0, in_ready=1. A subsequent 0001+0010 finish yields out_sum=0x03.
- finish in IDLE with no operands → out_sum=0x00, count=0, overflow=0 after 2 cycles.
